sdes_engine: RTL and testbench
==============================

Name: sdes_engine

Overview:
Parametrised, iterative S-DES block cipher core with encrypt/decrypt mode, valid/ready handshakes on both sides and a cached round-key schedule. Next generation of the fixed 2-round project encryptor: full S-boxes, selectable direction and configurable round count. Sits between the project input-capture logic and the output register bank of the user project area.

Parameters:
ROUNDS, 2, Feistel round count (2..8); 2 gives standard S-DES.
KEY_W, 10, key width; fixed at 10, generic only for the package interface.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
in_valid  input  1  request valid.
in_ready  output  1  engine can accept a request (high only in IDLE).
in_mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
in_key  input  10  key, bit 9 = S-DES bit 1; sampled on accept.
in_data  input  8  plaintext/ciphertext, bit 7 = S-DES bit 1; sampled on accept.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_data  output  8  result.
key_hit  output  1  pulse: last accept reused cached key schedule.

Behaviour:
- Reset (reset=0, any time, async): state=IDLE, out_valid=0, out_data=0, key_hit=0, cache-valid flag=0, round-key array cleared; in-flight operation abandoned, no output produced.
- Standard S-DES tables, MSB-first numbering: P10, P8, P4, IP, IP^-1, EP, S0, S1. Round key i: after P10, left-rotate each 5-bit half by 1 for i=1, by 2 more for each i>1 (cumulative); apply P8.
- Accept = in_valid && in_ready at a clk edge; latches mode, key, data (data through IP).
- States: IDLE, KEYGEN, ROUND, DONE.
  - IDLE: in_ready=1. On accept: if cache valid and in_key equals cached key -> ROUND (key_hit=1 for one cycle); else -> KEYGEN, cached key <- in_key, cache-valid <- 0.
  - KEYGEN: one round key per cycle into array[0..ROUNDS-1]; after ROUNDS cycles set cache-valid, -> ROUND.
  - ROUND: one Feistel round per cycle. Encrypt uses key index 0..ROUNDS-1, decrypt ROUNDS-1..0. Halves swapped after every round except the last. On final round edge: out_data <- IP^-1(result), out_valid <- 1, -> DONE.
  - DONE: out_valid and out_data held stable until out_ready=1; on that edge out_valid <- 0, -> IDLE. in_ready=0 throughout (no overlap).
- Latency, accept edge to out_valid high: 2*ROUNDS edges on key miss, ROUNDS on hit (ROUNDS=2: 4 / 2).
- in_valid during non-IDLE states ignored; inputs need not be stable after accept.
- out_ready while out_valid=0 has no effect.
- out_data keeps last result after handshake until next result load.
- Mode has no effect on caching: same key, alternate modes both hit.

Decomposition:
- Package sdes_pkg: localparams for P10, P8, P4, IP, IP^-1, EP index tables; S0/S1 as 16-entry 2-bit constant arrays; state encoding (3-bit); functions p10/p8/ls/ip/ip_inv/f_k.
- One sub-module: sdes_round (combinational: 8-bit state + 8-bit round key -> 8-bit state, swap-enable input). Key schedule and FSM stay in sdes_engine.

Test Plan:
- Encrypt, key 1010000010, data 10010111, ROUNDS=2 -> out_data 00111000 four edges after accept, key_hit=0; round keys 10100100 / 01000011 in array.
- Decrypt same key, data 00111000 immediately after -> 10010111 two edges after accept, key_hit pulse 1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid/out_data stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next edge.
- Reset asserted mid-ROUND -> outputs 0 immediately; next request with same key takes miss path (4-edge latency, key_hit=0).
- Random 200 key/data pairs, ROUNDS=2 and ROUNDS=4: decrypt(encrypt(x)) == x; ROUNDS=2 results match software model.
- Back-to-back requests, out_ready tied high, in_valid held high -> one accept per IDLE visit, no dropped or duplicated results.

Source files
------------

// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: permutation tables, S-boxes, FSM encoding and
// the bit-level helper functions used by the engine and its round datapath.
// Tables use the textbook MSB-first numbering: entry value n means
// "S-DES bit n", which lives at vector index (width - n).
package sdes_pkg;

  localparam int KEY_BITS = 10;
  localparam int BLK_BITS = 8;

  localparam int P10_T   [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_T    [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int P4_T    [4]  = '{2, 4, 3, 1};
  localparam int IP_T    [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IPINV_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EP_T    [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};

  // S-boxes flattened row-major; index = {row, col} = {b1, b4, b2, b3}
  localparam logic [1:0] S0_T [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1_T [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYGEN = 3'd1,
    ST_ROUND  = 3'd2,
    ST_DONE   = 3'd3
  } state_e;

  function automatic logic [9:0] p10(input logic [9:0] k);
    logic [9:0] r;
    r = '0;
    for (int j = 0; j < 10; j++) r[9-j] = k[10-P10_T[j]];
    return r;
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[7-j] = k[10-P8_T[j]];
    return r;
  endfunction

  // Rotate a 5-bit half left by n (0..4) places
  function automatic logic [4:0] ls(input logic [4:0] h, input logic [2:0] n);
    logic [9:0] d;
    d = {h, h} << n;
    return d[9:5];
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[7-j] = d[8-IP_T[j]];
    return r;
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[7-j] = d[8-IPINV_T[j]];
    return r;
  endfunction

  // Mixing function F: expand, add key, substitute, permute
  function automatic logic [3:0] sbox_f(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] x;
    logic [3:0] s;
    logic [3:0] o;
    x = '0;
    o = '0;
    for (int j = 0; j < 8; j++) x[7-j] = r[4-EP_T[j]];
    x = x ^ k;
    s = {S0_T[{x[7], x[4], x[6], x[5]}], S1_T[{x[3], x[0], x[2], x[1]}]};
    for (int j = 0; j < 4; j++) o[3-j] = s[4-P4_T[j]];
    return o;
  endfunction

  // One Feistel step without the half swap
  function automatic logic [7:0] f_k(input logic [7:0] st, input logic [7:0] k);
    return {st[7:4] ^ sbox_f(st[3:0], k), st[3:0]};
  endfunction

  // Round key idx (0-based): halves rotated by 1, then 2 more per round
  function automatic logic [7:0] gen_round_key(input logic [9:0] key, input int idx);
    logic [9:0] p;
    logic [2:0] amt;
    p   = p10(key);
    amt = 3'((2 * idx + 1) % 5);
    return p8({ls(p[9:5], amt), ls(p[4:0], amt)});
  endfunction

endpackage

// File: rtl/sdes_round.sv
// Combinational S-DES round: applies f_k with the given round key and
// optionally swaps the halves (every round except the last one).
module sdes_round
  import sdes_pkg::*;
(
  input  logic [7:0] state_i,
  input  logic [7:0] key_i,
  input  logic       swap_i,
  output logic [7:0] state_o
);

  logic [7:0] mixed;

  // Feistel mix followed by the optional half swap
  always_comb begin
    mixed   = f_k(state_i, key_i);
    state_o = swap_i ? {mixed[3:0], mixed[7:4]} : mixed;
  end

endmodule

// File: rtl/sdes_engine.sv
// Iterative S-DES engine: one round key per cycle during key generation,
// one Feistel round per cycle afterwards. The round-key schedule of the last
// key is kept so a repeated key (either direction) skips key generation.
module sdes_engine
  import sdes_pkg::*;
#(
  parameter int ROUNDS = 2,
  parameter int KEY_W  = KEY_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [KEY_W-1:0] in_key,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             key_hit
);

  localparam int CNT_W = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] cache_key_q, cache_key_d;
  logic             cache_valid_q, cache_valid_d;
  logic [7:0]       rk_q [ROUNDS];
  logic [7:0]       rk_d [ROUNDS];
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             key_hit_q, key_hit_d;

  logic             last_cnt;
  logic [CNT_W-1:0] key_idx;
  logic [7:0]       rk_sel;
  logic [7:0]       round_out;
  logic             key_match;

  // Round-key selection: decrypt walks the schedule backwards
  always_comb begin
    last_cnt  = (cnt_q == LAST_IDX);
    key_idx   = mode_q ? (LAST_IDX - cnt_q) : cnt_q;
    rk_sel    = rk_q[key_idx];
    key_match = cache_valid_q && (in_key == cache_key_q);
  end

  sdes_round u_round (
    .state_i (data_q),
    .key_i   (rk_sel),
    .swap_i  (!last_cnt),
    .state_o (round_out)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign key_hit   = key_hit_q;

  // Next-state and datapath update for the IDLE/KEYGEN/ROUND/DONE sequence
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    cache_key_d   = cache_key_q;
    cache_valid_d = cache_valid_q;
    rk_d          = rk_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    key_hit_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d = in_mode;
          data_d = ip(in_data);
          cnt_d  = '0;
          if (key_match) begin
            state_d   = ST_ROUND;
            key_hit_d = 1'b1;
          end else begin
            // Invalidate first so an abandoned keygen never looks cached
            state_d       = ST_KEYGEN;
            cache_key_d   = in_key;
            cache_valid_d = 1'b0;
          end
        end
      end

      ST_KEYGEN: begin
        rk_d[cnt_q] = gen_round_key(cache_key_q, int'(cnt_q));
        if (last_cnt) begin
          cnt_d         = '0;
          cache_valid_d = 1'b1;
          state_d       = ST_ROUND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_ROUND: begin
        data_d = round_out;
        if (last_cnt) begin
          out_data_d  = ip_inv(round_out);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, cache and output registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      data_q        <= '0;
      cnt_q         <= '0;
      cache_key_q   <= '0;
      cache_valid_q <= 1'b0;
      for (int i = 0; i < ROUNDS; i++) rk_q[i] <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      key_hit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      cache_key_q   <= cache_key_d;
      cache_valid_q <= cache_valid_d;
      rk_q          <= rk_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      key_hit_q     <= key_hit_d;
    end
  end

endmodule

// File: tb/tb_sdes_engine.sv
// Directed and randomised bench for sdes_engine. Two engines (2 and 4 rounds)
// share the request bus; 'sel' routes in_valid and selects which outputs are
// observed.
module tb_sdes_engine;

  localparam logic [9:0] KEY_A = 10'b1010000010;
  localparam logic [9:0] KEY_B = 10'b0111111101;

  localparam int S0M [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  localparam int S1M [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  logic       clk;
  logic       reset;
  logic       sel;
  logic       in_valid;
  logic       in_mode;
  logic [9:0] in_key;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_valid2, in_ready2, out_valid2, key_hit2;
  logic [7:0] out_data2;
  logic       in_valid4, in_ready4, out_valid4, key_hit4;
  logic [7:0] out_data4;

  logic       in_ready, out_valid, key_hit;
  logic [7:0] out_data;

  int checks;
  int errors;

  assign in_valid2 = in_valid && !sel;
  assign in_valid4 = in_valid && sel;
  assign in_ready  = sel ? in_ready4  : in_ready2;
  assign out_valid = sel ? out_valid4 : out_valid2;
  assign out_data  = sel ? out_data4  : out_data2;
  assign key_hit   = sel ? key_hit4   : key_hit2;

  sdes_engine #(.ROUNDS(2)) dut_r2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_mode   (in_mode),
    .in_key    (in_key),
    .in_data   (in_data),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .key_hit   (key_hit2)
  );

  sdes_engine #(.ROUNDS(4)) dut_r4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_mode   (in_mode),
    .in_key    (in_key),
    .in_data   (in_data),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .key_hit   (key_hit4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (standard 2-round S-DES) ----------------
  function automatic logic [3:0] model_f(input logic [3:0] r, input logic [7:0] sk);
    logic [7:0] x;
    logic [1:0] s0, s1;
    logic [3:0] s;
    x  = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ sk;
    s0 = 2'(S0M[{x[7], x[4]}][{x[6], x[5]}]);
    s1 = 2'(S1M[{x[3], x[0]}][{x[2], x[1]}]);
    s  = {s0, s1};
    return {s[2], s[0], s[1], s[3]};
  endfunction

  function automatic logic [7:0] model_p8(input logic [9:0] c);
    return {c[4], c[7], c[3], c[6], c[2], c[5], c[0], c[1]};
  endfunction

  function automatic logic [7:0] model_sdes(input logic [9:0] k, input logic [7:0] d, input logic dec);
    logic [9:0] p;
    logic [4:0] l1, r1, l2, r2;
    logic [7:0] k1, k2, ka, kb, t;
    logic [3:0] lh, rh, tmp;
    p  = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    l1 = {p[8:5], p[9]};
    r1 = {p[3:0], p[4]};
    k1 = model_p8({l1, r1});
    l2 = {l1[2:0], l1[4:3]};
    r2 = {r1[2:0], r1[4:3]};
    k2 = model_p8({l2, r2});
    ka = dec ? k2 : k1;
    kb = dec ? k1 : k2;
    t  = {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    lh = t[7:4];
    rh = t[3:0];
    lh = lh ^ model_f(rh, ka);
    tmp = lh; lh = rh; rh = tmp;
    lh = lh ^ model_f(rh, kb);
    t  = {lh, rh};
    return {t[4], t[7], t[5], t[3], t[1], t[6], t[0], t[2]};
  endfunction

  // ---------------- driver: one full request/response ----------------
  task automatic do_op(input logic s, input logic m, input logic [9:0] k, input logic [7:0] d,
                       output logic [7:0] res, output int lat, output logic hit);
    int guard;
    sel = s; in_mode = m; in_key = k; in_data = d;
    guard = 0;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_ready_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    // inputs are free to change once accepted
    in_valid = 1'b0; in_key = ~k; in_data = ~d; in_mode = ~m;
    hit = key_hit;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL op_result_timeout: out_valid=%b required 1 after %0d edges", out_valid, lat);
    end
    res = out_data;
    $display("op r%0d mode=%0d key=%b data=%b -> %b lat=%0d hit=%0d",
             s ? 4 : 2, m, k, d, res, lat, hit);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %b required 00000000", out_data); end
    checks++;
    if (key_hit !== 1'b0) begin errors++; $display("FAIL reset_key_hit: got %b required 0", key_hit); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_encrypt_miss();
    logic [7:0] res; int lat; logic hit;
    do_op(1'b0, 1'b0, KEY_A, 8'b10010111, res, lat, hit);
    checks++;
    if (res !== 8'b00111000) begin errors++; $display("FAIL enc_data: got %b required 00111000", res); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL enc_latency: got %0d required 4", lat); end
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL enc_key_hit: got %b required 0", hit); end
    checks++;
    if (dut_r2.rk_q[0] !== 8'b10100100) begin errors++; $display("FAIL enc_rk0: got %b required 10100100", dut_r2.rk_q[0]); end
    checks++;
    if (dut_r2.rk_q[1] !== 8'b01000011) begin errors++; $display("FAIL enc_rk1: got %b required 01000011", dut_r2.rk_q[1]); end
  endtask

  task automatic test_decrypt_hit();
    logic [7:0] res; int lat; logic hit;
    do_op(1'b0, 1'b1, KEY_A, 8'b00111000, res, lat, hit);
    checks++;
    if (res !== 8'b10010111) begin errors++; $display("FAIL dec_data: got %b required 10010111", res); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL dec_latency: got %0d required 2", lat); end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL dec_key_hit: got %b required 1", hit); end
    checks++;
    if (key_hit !== 1'b0) begin errors++; $display("FAIL dec_key_hit_pulse: got %b required 0", key_hit); end
  endtask

  task automatic test_backpressure();
    int guard;
    sel = 1'b0; in_mode = 1'b0; in_key = KEY_A; in_data = 8'b01110010;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_result_timeout: out_valid=%b required 1", out_valid); end
    // a competing request is offered while the result is stalled
    in_valid = 1'b1; in_key = KEY_B; in_data = 8'hA5; in_mode = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'b01110111 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b out_data=%b in_ready=%b required 1/01110111/0",
                 c, out_valid, out_data, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("bp released: out_valid=%b in_ready=%b out_data=%b", out_valid, in_ready, out_data);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
    checks++;
    if (out_data !== 8'b01110111) begin errors++; $display("FAIL bp_data_kept: got %b required 01110111", out_data); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ignored_request: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_round();
    logic [7:0] res; int lat; logic hit;
    sel = 1'b0; in_mode = 1'b0; in_key = KEY_A; in_data = 8'b10010111;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    $display("reset mid-round: out_valid=%b out_data=%b in_ready=%b", out_valid, out_data, in_ready);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %b required 00000000", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output: got %b required 0", out_valid); end
    do_op(1'b0, 1'b0, KEY_A, 8'b10010111, res, lat, hit);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL midrst_latency: got %0d required 4", lat); end
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL midrst_key_hit: got %b required 0", hit); end
    checks++;
    if (res !== 8'b00111000) begin errors++; $display("FAIL midrst_data_after: got %b required 00111000", res); end
  endtask

  task automatic test_random();
    logic [9:0] k, prev2, prev4;
    logic       pv2, pv4, exp_hit;
    logic [7:0] d, enc, dec;
    int lat; logic hit;
    prev2 = KEY_A; pv2 = 1'b1;
    prev4 = '0;    pv4 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      k = 10'($urandom);
      d = 8'($urandom);
      // two-round engine against the reference model
      exp_hit = pv2 && (k == prev2);
      do_op(1'b0, 1'b0, k, d, enc, lat, hit);
      checks++;
      if (enc !== model_sdes(k, d, 1'b0)) begin
        errors++; $display("FAIL rnd2_enc[%0d]: got %b required %b", i, enc, model_sdes(k, d, 1'b0));
      end
      checks++;
      if (hit !== exp_hit || lat != (exp_hit ? 2 : 4)) begin
        errors++; $display("FAIL rnd2_enc_timing[%0d]: hit=%b lat=%0d required hit=%b", i, hit, lat, exp_hit);
      end
      do_op(1'b0, 1'b1, k, enc, dec, lat, hit);
      checks++;
      if (dec !== d) begin errors++; $display("FAIL rnd2_dec[%0d]: got %b required %b", i, dec, d); end
      checks++;
      if (hit !== 1'b1 || lat != 2) begin
        errors++; $display("FAIL rnd2_dec_timing[%0d]: hit=%b lat=%0d required hit=1 lat=2", i, hit, lat);
      end
      prev2 = k; pv2 = 1'b1;
      // four-round engine round trip
      exp_hit = pv4 && (k == prev4);
      do_op(1'b1, 1'b0, k, d, enc, lat, hit);
      checks++;
      if (hit !== exp_hit || lat != (exp_hit ? 4 : 8)) begin
        errors++; $display("FAIL rnd4_enc_timing[%0d]: hit=%b lat=%0d required hit=%b", i, hit, lat, exp_hit);
      end
      do_op(1'b1, 1'b1, k, enc, dec, lat, hit);
      checks++;
      if (dec !== d) begin errors++; $display("FAIL rnd4_dec[%0d]: got %b required %b", i, dec, d); end
      checks++;
      if (hit !== 1'b1 || lat != 4) begin
        errors++; $display("FAIL rnd4_dec_timing[%0d]: hit=%b lat=%0d required hit=1 lat=4", i, hit, lat);
      end
      prev4 = k; pv4 = 1'b1;
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] keys  [6];
    logic [7:0] datas [6];
    logic       modes [6];
    logic [7:0] expv  [6];
    logic [7:0] got_data;
    logic       acc, got;
    int idx_in, idx_out, cyc;
    keys  = '{KEY_A, KEY_A, KEY_A, KEY_B, KEY_B, KEY_A};
    datas = '{8'b10010111, 8'b01110010, 8'h3C, 8'hF0, 8'h0F, 8'b00111000};
    modes = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) expv[i] = model_sdes(keys[i], datas[i], modes[i]);
    sel = 1'b0;
    out_ready = 1'b1;
    idx_in = 0; idx_out = 0; cyc = 0;
    in_key = keys[0]; in_data = datas[0]; in_mode = modes[0];
    in_valid = 1'b1;
    while (idx_out < 6 && cyc < 300) begin
      acc = in_ready && in_valid;
      got = out_valid;
      got_data = out_data;
      @(posedge clk); #1;
      cyc++;
      if (got) begin
        $display("b2b result %0d: %b expected %b", idx_out, got_data, expv[idx_out]);
        checks++;
        if (got_data !== expv[idx_out]) begin
          errors++; $display("FAIL b2b_data[%0d]: got %b required %b", idx_out, got_data, expv[idx_out]);
        end
        idx_out++;
      end
      if (acc) begin
        idx_in++;
        if (idx_in < 6) begin
          in_key = keys[idx_in]; in_data = datas[idx_in]; in_mode = modes[idx_in];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx_in != 6) begin errors++; $display("FAIL b2b_accepts: got %0d required 6", idx_in); end
    checks++;
    if (idx_out != 6) begin errors++; $display("FAIL b2b_results: got %0d required 6", idx_out); end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_result: out_valid=%b required 0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    sel = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    test_reset();
    test_encrypt_miss();
    test_decrypt_hit();
    test_backpressure();
    test_reset_mid_round();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
